// File: rtl/dm_abstract_cmd.sv
// rtl/dm_abstract_cmd.sv - debug-module abstract command engine (Access Register + progbuf exec)
// Optional watchdog on the core handshakes: define DM_ABSTRACT_TIMEOUT_EN.
module dm_abstract_cmd #(
  parameter int ARG_DW      = 128,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cmd_wen,
  input  logic [31:0]       cmd_wdata,
  input  logic              data_wen,
  input  logic [1:0]        data_sel,
  input  logic [31:0]       data_wdata,
  input  logic [1:0]        data_raddr,
  output logic [31:0]       data_rdata,
  input  logic [2:0]        cmderr_w1c,
  output logic              busy,
  output logic [2:0]        cmderr,
  input  logic              isHalt,
  output logic              accessReg_vaild,
  input  logic              accessReg_ready,
  output logic [15:0]       accessReg_addr,
  output logic              accessReg_wen,
  output logic [ARG_DW-1:0] accessReg_arg,
  input  logic [ARG_DW-1:0] accessReg_res,
  output logic              quickAccess_vaild,
  input  logic              quickAccess_ready,
  input  logic              isExpection
);

  typedef enum logic [1:0] {IDLE, XFER, EXEC} stateT;

  stateT       state, nextState;
  logic [31:0] dataReg [4];
  logic [15:0] regNo;
  logic [2:0]  latSize;
  logic        latWrite, latPostInc, latPostExec;

  logic [7:0]  cmdType;
  logic [2:0]  aarSize;
  logic        postInc, postExec, transfer, writeOp, badCmd, unusedCmdBit;

  assign cmdType      = cmd_wdata[31:24];
  assign unusedCmdBit = cmd_wdata[23];
  assign aarSize      = cmd_wdata[22:20];
  assign postInc      = cmd_wdata[19];
  assign postExec     = cmd_wdata[18];
  assign transfer     = cmd_wdata[17];
  assign writeOp      = cmd_wdata[16];
  assign badCmd       = (cmdType != 8'd0) ||
                        (transfer && !(aarSize == 3'd2 || aarSize == 3'd3 || aarSize == 3'd4));

  logic       errSet, accept, xferDone, timeoutHit, handshakeDone;
  logic [2:0] errCode;

  assign handshakeDone = (state == XFER && accessReg_ready) || (state == EXEC && quickAccess_ready);

`ifdef DM_ABSTRACT_TIMEOUT_EN
  localparam int CntW = $clog2(TIMEOUT_CYC + 1);
  logic [CntW-1:0] toCnt;

  // Counter reads 0 on the first cycle of each busy state, so TIMEOUT_CYC busy cycles elapse before abort.
  assign timeoutHit = (state != IDLE) && (toCnt == CntW'(TIMEOUT_CYC - 1)) && !handshakeDone;

  always_ff @(posedge CLK) begin
    if (RST || state == IDLE || nextState != state) toCnt <= '0;
    else                                             toCnt <= toCnt + 1'b1;
  end
`else
  assign timeoutHit = 1'b0;
`endif

  always_comb begin
    nextState = state;
    errSet    = 1'b0;
    errCode   = 3'd0;
    accept    = 1'b0;
    xferDone  = 1'b0;
    if (state != IDLE && (cmd_wen || data_wen)) begin
      errSet  = 1'b1;
      errCode = 3'd1;
    end
    unique case (state)
      IDLE: begin
        if (cmd_wen && cmderr == 3'd0) begin
          if (badCmd) begin
            errSet  = 1'b1;
            errCode = 3'd2;
          end else if (!isHalt) begin
            errSet  = 1'b1;
            errCode = 3'd4;
          end else begin
            accept = 1'b1;
            if (transfer)      nextState = XFER;
            else if (postExec) nextState = EXEC;
          end
        end
      end
      XFER: begin
        if (accessReg_ready) begin
          xferDone  = 1'b1;
          nextState = latPostExec ? EXEC : IDLE;
        end
      end
      EXEC: begin
        if (quickAccess_ready) begin
          nextState = IDLE;
          if (isExpection) begin
            errSet  = 1'b1;
            errCode = 3'd3;
          end
        end
      end
      default: nextState = IDLE;
    endcase
    if (timeoutHit) begin
      nextState = IDLE;
      errSet    = 1'b1;
      errCode   = 3'd7;
      xferDone  = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      cmderr      <= 3'd0;
      regNo       <= 16'd0;
      latSize     <= 3'd0;
      latWrite    <= 1'b0;
      latPostInc  <= 1'b0;
      latPostExec <= 1'b0;
      for (int i = 0; i < 4; i++) dataReg[i] <= 32'd0;
    end else begin
      state <= nextState;
      if (errSet && cmderr == 3'd0) cmderr <= errCode;
      else                          cmderr <= cmderr & ~cmderr_w1c;
      if (data_wen && state == IDLE) dataReg[data_sel] <= data_wdata;
      if (accept) begin
        regNo       <= cmd_wdata[15:0];
        latSize     <= aarSize;
        latWrite    <= writeOp;
        latPostInc  <= postInc;
        latPostExec <= postExec;
      end
      if (xferDone) begin
        if (!latWrite) begin
          dataReg[0] <= accessReg_res[31:0];
          if (latSize != 3'd2) dataReg[1] <= accessReg_res[63:32];
          if (latSize == 3'd4) begin
            dataReg[2] <= accessReg_res[95:64];
            dataReg[3] <= accessReg_res[127:96];
          end
        end
        if (latPostInc) regNo <= regNo + 16'd1;
      end
    end
  end

  always_comb begin
    accessReg_arg = '0;
    unique case (latSize)
      3'd2:    accessReg_arg[31:0] = dataReg[0];
      3'd3:    accessReg_arg[63:0] = {dataReg[1], dataReg[0]};
      default: accessReg_arg       = {dataReg[3], dataReg[2], dataReg[1], dataReg[0]};
    endcase
  end

  assign data_rdata        = dataReg[data_raddr];
  assign busy              = (state != IDLE);
  assign accessReg_vaild   = (state == XFER);
  assign quickAccess_vaild = (state == EXEC);
  assign accessReg_addr    = regNo;
  assign accessReg_wen     = latWrite;

endmodule

// File: tb/tb_dm_abstract_cmd.sv
// tb/tb_dm_abstract_cmd.sv - self-checking bench for dm_abstract_cmd
module tb_dm_abstract_cmd;
`ifdef DM_ABSTRACT_TIMEOUT_EN
  localparam int TB_TO = 8;
`else
  localparam int TB_TO = 1023;
`endif

  logic         CLK, RST;
  logic         cmd_wen, data_wen, isHalt;
  logic [31:0]  cmd_wdata, data_wdata, data_rdata;
  logic [1:0]   data_sel, data_raddr;
  logic [2:0]   cmderr_w1c, cmderr;
  logic         busy, accessReg_vaild, accessReg_ready, accessReg_wen;
  logic [15:0]  accessReg_addr;
  logic [127:0] accessReg_arg, accessReg_res;
  logic         quickAccess_vaild, quickAccess_ready, isExpection;

  dm_abstract_cmd #(.ARG_DW(128), .TIMEOUT_CYC(TB_TO)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_wen(cmd_wen), .cmd_wdata(cmd_wdata),
    .data_wen(data_wen), .data_sel(data_sel), .data_wdata(data_wdata),
    .data_raddr(data_raddr), .data_rdata(data_rdata),
    .cmderr_w1c(cmderr_w1c), .busy(busy), .cmderr(cmderr), .isHalt(isHalt),
    .accessReg_vaild(accessReg_vaild), .accessReg_ready(accessReg_ready),
    .accessReg_addr(accessReg_addr), .accessReg_wen(accessReg_wen),
    .accessReg_arg(accessReg_arg), .accessReg_res(accessReg_res),
    .quickAccess_vaild(quickAccess_vaild), .quickAccess_ready(quickAccess_ready),
    .isExpection(isExpection)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int nCmp = 0;
  int nBad = 0;

  typedef struct {
    logic [31:0]  cmd;
    logic         halt;
    logic [2:0]   expErr;
    logic         expBusy;
    logic         expAv;
    logic         expQv;
    logic         chkXfer;
    logic [15:0]  expAddr;
    logic         expWen;
    logic [127:0] expArg;
  } vecT;

  vecT vecs [11];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic doReset;
    cmd_wen = 0; cmd_wdata = 0; data_wen = 0; data_sel = 0; data_wdata = 0;
    data_raddr = 0; cmderr_w1c = 0; isHalt = 0; accessReg_ready = 0;
    accessReg_res = 0; quickAccess_ready = 0; isExpection = 0;
    RST = 1;
    tick;
    RST = 0;
  endtask

  task automatic wrData(input logic [1:0] sel, input logic [31:0] val);
    data_wen = 1; data_sel = sel; data_wdata = val;
    tick;
    data_wen = 0;
  endtask

  task automatic rdChk(input string name, input logic [1:0] idx, input logic [31:0] exp);
    data_raddr = idx;
    #1;
    chk(name, data_rdata, exp);
  endtask

  task automatic issue(input logic [31:0] cmd);
    cmd_wen = 1; cmd_wdata = cmd;
    tick;
    cmd_wen = 0;
  endtask

  initial begin
    vecs[0]  = '{32'h0023_1001, 1, 3'd0, 1, 1, 0, 1, 16'h1001, 1, 128'h1234_5678};
    vecs[1]  = '{32'h0033_2000, 1, 3'd0, 1, 1, 0, 1, 16'h2000, 1, 128'h9ABC_DEF0_1234_5678};
    vecs[2]  = '{32'h0043_0010, 1, 3'd0, 1, 1, 0, 1, 16'h0010, 1,
                 128'hCAFE_BABE_0BAD_F00D_9ABC_DEF0_1234_5678};
    vecs[3]  = '{32'h0223_1001, 1, 3'd2, 0, 0, 0, 0, 16'h0, 0, 128'h0};
    vecs[4]  = '{32'h0013_1001, 1, 3'd2, 0, 0, 0, 0, 16'h0, 0, 128'h0};
    vecs[5]  = '{32'h0023_1001, 0, 3'd4, 0, 0, 0, 0, 16'h0, 0, 128'h0};
    vecs[6]  = '{32'h0000_1001, 1, 3'd0, 0, 0, 0, 0, 16'h0, 0, 128'h0};
    vecs[7]  = '{32'h0004_0000, 1, 3'd0, 1, 0, 1, 0, 16'h0, 0, 128'h0};
    vecs[8]  = '{32'h0054_0000, 1, 3'd0, 1, 0, 1, 0, 16'h0, 0, 128'h0};
    vecs[9]  = '{32'h0142_0000, 0, 3'd2, 0, 0, 0, 0, 16'h0, 0, 128'h0};
    vecs[10] = '{32'h0022_0300, 1, 3'd0, 1, 1, 0, 1, 16'h0300, 0, 128'h1234_5678};

    doReset;
    chk("rst_busy", busy, 0);
    chk("rst_cmderr", cmderr, 0);
    chk("rst_av", accessReg_vaild, 0);
    chk("rst_qv", quickAccess_vaild, 0);
    chk("rst_addr", accessReg_addr, 0);
    chk("rst_wen", accessReg_wen, 0);
    chk("rst_arg", accessReg_arg, 0);
    for (int i = 0; i < 4; i++) rdChk($sformatf("rst_data%0d", i), 2'(i), 32'h0);

    for (int v = 0; v < 11; v++) begin
      doReset;
      wrData(0, 32'h1234_5678);
      wrData(1, 32'h9ABC_DEF0);
      wrData(2, 32'h0BAD_F00D);
      wrData(3, 32'hCAFE_BABE);
      isHalt = vecs[v].halt;
      issue(vecs[v].cmd);
      chk($sformatf("v%0d_cmderr", v), cmderr, vecs[v].expErr);
      chk($sformatf("v%0d_busy", v), busy, vecs[v].expBusy);
      chk($sformatf("v%0d_av", v), accessReg_vaild, vecs[v].expAv);
      chk($sformatf("v%0d_qv", v), quickAccess_vaild, vecs[v].expQv);
      if (vecs[v].chkXfer) begin
        chk($sformatf("v%0d_addr", v), accessReg_addr, vecs[v].expAddr);
        chk($sformatf("v%0d_wen", v), accessReg_wen, vecs[v].expWen);
        chk($sformatf("v%0d_arg", v), accessReg_arg, vecs[v].expArg);
      end
    end

    // write transfer: latency, stable hold, busy drop after ready
    doReset;
    isHalt = 1;
    wrData(0, 32'h1234_5678);
    cmd_wen = 1; cmd_wdata = 32'h0023_1001;
    #1;
    chk("s1_av_cycN", accessReg_vaild, 0);
    tick;
    cmd_wen = 0;
    chk("s1_av_n1", accessReg_vaild, 1);
    tick;
    chk("s1_av_hold", accessReg_vaild, 1);
    chk("s1_arg_hold", accessReg_arg, 128'h1234_5678);
    chk("s1_addr_hold", accessReg_addr, 16'h1001);
    accessReg_ready = 1;
    #1;
    chk("s1_busy_at_ready", busy, 1);
    tick;
    accessReg_ready = 0;
    chk("s1_busy_after", busy, 0);
    chk("s1_av_after", accessReg_vaild, 0);

    // 64-bit read capture
    doReset;
    isHalt = 1;
    wrData(0, 32'h5555_0000); wrData(1, 32'h6666_0000);
    wrData(2, 32'h2222_2222); wrData(3, 32'h3333_3333);
    issue(32'h0032_1002);
    accessReg_res = 128'hAAAA_BBBB_CCCC_DDDD_1111_2222_3333_4444;
    accessReg_ready = 1;
    tick;
    accessReg_ready = 0;
    rdChk("s2_data0", 0, 32'h3333_4444);
    rdChk("s2_data1", 1, 32'h1111_2222);
    rdChk("s2_data2", 2, 32'h2222_2222);
    rdChk("s2_data3", 3, 32'h3333_3333);

    // postincrement + postexec with exception
    doReset;
    isHalt = 1;
    issue(32'h003E_1005);
    chk("s3_av", accessReg_vaild, 1);
    chk("s3_wen", accessReg_wen, 0);
    accessReg_ready = 1;
    tick;
    accessReg_ready = 0;
    chk("s3_qv", quickAccess_vaild, 1);
    chk("s3_av_off", accessReg_vaild, 0);
    chk("s3_addr_inc", accessReg_addr, 16'h1006);
    quickAccess_ready = 1; isExpection = 1;
    tick;
    quickAccess_ready = 0; isExpection = 0;
    chk("s3_cmderr", cmderr, 3'd3);
    chk("s3_busy", busy, 0);
    cmderr_w1c = 3'b111;
    tick;
    cmderr_w1c = 0;
    chk("s3_w1c", cmderr, 3'd0);

    // busy collisions, sticky cmderr, w1c masking, set-vs-clear priority
    doReset;
    isHalt = 1;
    wrData(0, 32'hA5A5_A5A5);
    issue(32'h0023_1001);
    cmd_wen = 1; cmd_wdata = 32'h0023_2002;
    data_wen = 1; data_sel = 0; data_wdata = 32'hFFFF_FFFF;
    tick;
    cmd_wen = 0; data_wen = 0;
    chk("s4_cmderr1", cmderr, 3'd1);
    chk("s4_av", accessReg_vaild, 1);
    chk("s4_addr", accessReg_addr, 16'h1001);
    chk("s4_arg", accessReg_arg, 128'hA5A5_A5A5);
    cmderr_w1c = 3'b110; accessReg_ready = 1;
    tick;
    cmderr_w1c = 0; accessReg_ready = 0;
    chk("s4_partial_w1c", cmderr, 3'd1);
    chk("s4_busy", busy, 0);
    issue(32'h0023_1001);
    chk("s4_ignored", busy, 0);
    chk("s4_sticky", cmderr, 3'd1);
    cmderr_w1c = 3'b001;
    tick;
    cmderr_w1c = 0;
    chk("s4_clear", cmderr, 3'd0);
    cmderr_w1c = 3'b111;
    issue(32'h0223_0000);
    cmderr_w1c = 0;
    chk("s4_set_prio", cmderr, 3'd2);

    // reset during transfer
    doReset;
    isHalt = 1;
    wrData(1, 32'h1111_1111);
    issue(32'h0023_1001);
    chk("s5_av_pre", accessReg_vaild, 1);
    RST = 1;
    tick;
    RST = 0;
    chk("s5_av", accessReg_vaild, 0);
    chk("s5_busy", busy, 0);
    chk("s5_addr", accessReg_addr, 0);
    for (int i = 0; i < 4; i++) rdChk($sformatf("s5_data%0d", i), 2'(i), 32'h0);

    // regno wrap on postincrement
    doReset;
    isHalt = 1;
    issue(32'h002A_FFFF);
    accessReg_ready = 1;
    tick;
    accessReg_ready = 0;
    chk("s6_busy", busy, 0);
    chk("s6_wrap", accessReg_addr, 16'h0000);

    // data write coinciding with command write
    doReset;
    isHalt = 1;
    data_wen = 1; data_sel = 0; data_wdata = 32'hDEAD_BEEF;
    issue(32'h0023_0001);
    data_wen = 0;
    chk("s7_arg", accessReg_arg, 128'hDEAD_BEEF);
    chk("s7_cmderr", cmderr, 3'd0);

`ifdef DM_ABSTRACT_TIMEOUT_EN
    doReset;
    isHalt = 1;
    issue(32'h0023_1001);
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("to_av_c%0d", c), accessReg_vaild, 1);
      tick;
    end
    chk("to_av_drop", accessReg_vaild, 0);
    chk("to_busy", busy, 0);
    chk("to_cmderr", cmderr, 3'd7);
    accessReg_ready = 1;
    tick;
    accessReg_ready = 0;
    chk("to_late_ready", cmderr, 3'd7);
`else
    doReset;
    isHalt = 1;
    issue(32'h0023_1001);
    for (int c = 0; c < 20; c++) tick;
    chk("nto_av_held", accessReg_vaild, 1);
    chk("nto_cmderr", cmderr, 3'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
